// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and sample-point constants for the UART receiver (macro UART_RX_MAJORITY_EN)
package uart_pkg;

  // Default number of sample_tick strobes per bit period
  localparam int UART_DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Count at which a single-sample receiver looks at the line (centre of the bit)
  function automatic int mid_pt(input int oversample);
    return oversample / 2 - 1;
  endfunction

  // Count at which the bit decision is taken; the 2-of-3 vote needs one sample past centre
  function automatic int sample_pt(input int oversample);
`ifdef UART_RX_MAJORITY_EN
    return mid_pt(oversample) + 1;
`else
    return mid_pt(oversample);
`endif
  endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// rtl/uart_rx_vote.sv - 3-sample shift and 2-of-3 majority vote for the UART receiver
module uart_rx_vote (
  input  logic clk,
  input  logic rst,
  input  logic capture,
  input  logic rx_in,
  output logic voted
);

  logic [1:0] hist;

  // Hold the two samples taken before the decision point
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b00;
    end else if (capture) begin
      hist <= {hist[0], rx_in};
    end
  end

  // The third sample is the live line at the decision tick
  assign voted = (hist[1] & hist[0]) | (hist[1] & rx_in) | (hist[0] & rx_in);

endmodule

// File: rtl/uart_rx_sample_ctrl.sv
// rtl/uart_rx_sample_ctrl.sv - UART receive frame sequencer: start/false-start, mid-bit sampling, stop check (macro UART_RX_MAJORITY_EN)
module uart_rx_sample_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_tick,
  input  logic                           rx_in,
  input  logic                           enable,
  output logic                           shift_en,
  output logic                           shift_bit,
  output logic [$clog2(DATA_BITS+1)-1:0] bit_idx,
  output logic                           char_done,
  output logic                           frame_err,
  output logic                           busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] SMP_C     = CW'(sample_pt(OVERSAMPLE));
  localparam logic [CW-1:0] LAST_C    = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          stop_cnt;
  logic          err;
  logic          voted;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] PRE_C = CW'(mid_pt(OVERSAMPLE) - 1);
  localparam logic [CW-1:0] MID_C = CW'(mid_pt(OVERSAMPLE));

  logic capture;

  // Samples at MID-1 and MID feed the vote; the MID+1 sample is taken live
  assign capture = sample_tick && (cnt == PRE_C || cnt == MID_C);

  uart_rx_vote u_vote (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .rx_in   (rx_in),
    .voted   (voted)
  );
`else
  assign voted = rx_in;
`endif

  // Sample counter wraps explicitly so non-power-of-two oversampling works
  assign cnt_next = (cnt == LAST_C) ? '0 : cnt + 1'b1;

  // Frame sequencer with registered pulses; abort on disable beats tick processing
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      err       <= 1'b0;
      shift_en  <= 1'b0;
      shift_bit <= 1'b0;
      char_done <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      shift_en  <= 1'b0;
      char_done <= 1'b0;
      frame_err <= 1'b0;
      if (state != IDLE && !enable) begin
        state    <= IDLE;
        cnt      <= '0;
        bit_idx  <= '0;
        stop_cnt <= 1'b0;
        busy     <= 1'b0;
      end else if (sample_tick) begin
        case (state)
          IDLE: begin
            if (enable && !rx_in) begin
              state    <= START;
              cnt      <= CW'(1);
              bit_idx  <= '0;
              stop_cnt <= 1'b0;
              err      <= 1'b0;
              busy     <= 1'b1;
            end
          end
          START: begin
            if (cnt == SMP_C && voted) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt_next;
              if (cnt == LAST_C) begin
                state   <= DATA;
                bit_idx <= '0;
              end
            end
          end
          DATA: begin
            cnt <= cnt_next;
            if (cnt == SMP_C) begin
              shift_en  <= 1'b1;
              shift_bit <= voted;
            end
            if (cnt == LAST_C) begin
              if (bit_idx == LAST_BIT) begin
                state    <= STOP;
                stop_cnt <= 1'b0;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          STOP: begin
            cnt <= cnt_next;
            if (cnt == LAST_C) begin
              stop_cnt <= stop_cnt + 1'b1;
            end
            if (cnt == SMP_C) begin
              if (stop_cnt == LAST_STOP) begin
                // Leave at mid-bit so a back-to-back start edge is not missed
                char_done <= 1'b1;
                frame_err <= err | ~voted;
                state     <= IDLE;
                cnt       <= '0;
                bit_idx   <= '0;
                busy      <= 1'b0;
              end else begin
                err <= err | ~voted;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_sample_ctrl.md
Name: uart_rx_sample_ctrl

Overview:
- Parametrised successor to the 16x UART receive bit-sample counter.
- Owns the full receive frame: start detection, false-start rejection, mid-bit sampling and data-bit counting.
- Also handles stop-bit checking and char-done and framing-error reporting.
- Sits between the rx input synchroniser and the receive shift register / character buffer.

Parameters:
- OVERSAMPLE, 16, sample_tick strobes per bit period; even, minimum 4.
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- STOP_BITS, 1, stop bits checked (1 or 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sample_tick  in  1  one-clk strobe at baud*OVERSAMPLE; all counting advances only on ticks.
- rx_in  in  1  synchronised serial line, idle high.
- enable  in  1  receiver enable.
- shift_en  out  1  one-clk pulse: load shift_bit into the shift register.
- shift_bit  out  1  sampled data bit, valid while shift_en is high.
- bit_idx  out  $clog2(DATA_BITS+1)  index of the data bit currently being received.
- char_done  out  1  one-clk pulse at the end of a frame.
- frame_err  out  1  valid with char_done; 1 if any stop sample was 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; sample count, bit_idx and stop count all 0; every output 0.
- Sample counter: width $clog2(OVERSAMPLE), wraps from OVERSAMPLE-1 to 0.
- MID = OVERSAMPLE/2-1. SAMPLE_PT = MID+1 with majority vote, MID without.
- All outputs are registered. Each pulse appears the clk after the qualifying sample_tick and lasts exactly one clk.
- IDLE: on a tick with enable=1 and rx_in=0, go to START with count=1. Otherwise hold.
- START: advance count on each tick.
  - At SAMPLE_PT, a voted 1 is a false start: return to IDLE, no outputs.
  - At count=OVERSAMPLE-1, go to DATA with count=0 and bit_idx=0.
- DATA:
  - At SAMPLE_PT, pulse shift_en with shift_bit = voted sample.
  - At OVERSAMPLE-1, if bit_idx=DATA_BITS-1, go to STOP with count=0. Otherwise increment bit_idx.
- STOP:
  - At SAMPLE_PT, record the voted sample; a 0 sets the internal err flag.
  - On the last stop bit's SAMPLE_PT: pulse char_done with frame_err=err, then go to IDLE. Returning at mid-bit allows resync on a back-to-back start.
  - With STOP_BITS=2, the first stop bit runs the full OVERSAMPLE ticks before the second.
- Clock cycles without sample_tick change nothing.
- enable=0 in any non-IDLE state: abort to IDLE next clk. No char_done; the partial character is discarded.
- rst mid-frame: next clk is in reset state; no pulses.
- err flag clears on entry to START.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: the line is sampled at counts MID-1, MID and MID+1; the voted bit is 2-of-3 and the decision is taken at MID+1.
- Undefined: a single sample at MID; the vote logic is removed.
- The start-bit check uses the same rule as the data bits in both cases.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef rx_state_t (IDLE, START, DATA, STOP);
  - function-style constants for MID and SAMPLE_PT;
  - a shared default-OVERSAMPLE constant.
- One sub-module, uart_rx_vote: 3-sample shift/majority, instantiated only under UART_RX_MAJORITY_EN.

Test Plan:
- All tests use OVERSAMPLE=16, DATA_BITS=8, STOP_BITS=1, sample_tick every 4 clk, enable=1.
- Frame 0x55 with valid stop: 8 shift_en pulses with shift_bit 1,0,1,0,1,0,1,0 and bit_idx 0..7, then one char_done with frame_err=0.
- rx_in low for 3 ticks, then high: return to IDLE, busy drops, no shift_en or char_done.
- Frame 0xA3 with stop bit held 0: shift_bit sequence 1,1,0,0,0,1,0,1, then char_done with frame_err=1.
- Frame 0xFF with rx_in glitched low for exactly one tick at bit-3 count MID:
  - with the macro, bit 3 = 1;
  - without the macro, bit 3 = 0.
- rst asserted on bit 4 of a frame: next clk busy=0 and bit_idx=0, no char_done. A following frame 0x0F receives correctly.
- enable dropped during bit 2: abort, no char_done. Two back-to-back frames 0x12 and 0x34 with enable=1 give two char_done pulses, both with frame_err=0.
